// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined shifter: op encodings, stage payload, op helpers.
package shift_pkg;

  localparam int MAX_XLEN = 64;
  localparam int MAX_SHW  = 6;

  typedef enum logic [2:0] {
    SH_SLL = 3'b000,
    SH_SRL = 3'b001,
    SH_SRA = 3'b010,
    SH_ROL = 3'b011,
    SH_ROR = 3'b100
  } shift_op_e;

  // One pipeline slot; sized for the widest datapath, narrower builds use the low bits.
  typedef struct packed {
    logic                valid;
    logic [2:0]          op;
    logic                word;
    logic [MAX_SHW-1:0]  shamt;
    logic [MAX_XLEN-1:0] data;
  } shift_payload_t;

  // Left ops run through the right-shift core on a bit-reversed operand.
  function automatic logic op_is_left(input logic [2:0] op);
    return (op == SH_SLL) || (op == SH_ROL);
  endfunction

  function automatic logic op_is_rotate(input logic [2:0] op);
    return (op == SH_ROL) || (op == SH_ROR);
  endfunction

  // Encodings above SH_ROR return the operand untouched.
  function automatic logic op_is_pass(input logic [2:0] op);
    return op > SH_ROR;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// Combinational slice of the right-shift barrel: applies levels FIRST_LVL .. FIRST_LVL+NUM_LVL-1.
module shift_stage
  import shift_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int FIRST_LVL = 0,
  parameter int NUM_LVL   = 1
) (
  input  logic [2:0]              op,
  input  logic [$clog2(XLEN)-1:0] shamt,
  input  logic [XLEN-1:0]         data_in,
  output logic [XLEN-1:0]         data_out
);

  logic            rot;
  logic            sgn;
  logic [XLEN-1:0] v;

  assign rot = op_is_rotate(op);
  assign sgn = (op == SH_SRA);

  // Each enabled level shifts right by 2^level; vacated bits take wrapped, sign or zero fill.
  always_comb begin
    v = data_in;
    for (int i = 0; i < NUM_LVL; i++) begin
      if (shamt[FIRST_LVL+i]) begin
        if (rot)
          v = (v >> (1 << (FIRST_LVL + i))) | (v << (XLEN - (1 << (FIRST_LVL + i))));
        else if (sgn)
          v = $signed(v) >>> (1 << (FIRST_LVL + i));
        else
          v = v >> (1 << (FIRST_LVL + i));
      end
    end
    data_out = v;
  end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter with valid/ready handshake, word mode, rotates and flush.
module pipelined_shifter
  import shift_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         in_a,
  input  logic [$clog2(XLEN)-1:0] in_shamt,
  input  logic [2:0]              in_op,
  input  logic                    in_word,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_r
);

  localparam int SHW = $clog2(XLEN);
  localparam int LPS = (SHW + STAGES - 1) / STAGES;  // barrel levels per stage

  logic            adv;
  logic            word_eff;
  logic [SHW-1:0]  shamt_eff;
  logic [XLEN-1:0] word_data;
  logic [XLEN-1:0] sel_data;
  logic [XLEN-1:0] sel_rev;
  logic [XLEN-1:0] pre_data;
  logic [XLEN-1:0] fin_data;
  logic [XLEN-1:0] fin_rev;
  logic [XLEN-1:0] fin_norm;
  logic [XLEN-1:0] sext_r;

  shift_payload_t in_payload;
  shift_payload_t fin;
  shift_payload_t stage_next [STAGES];
  shift_payload_t stage_reg  [STAGES];

  // Global stall: everything moves when the output slot is empty or being drained.
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv & ~flush;
  assign out_valid = stage_reg[STAGES-1].valid;
  assign word_eff  = in_word & (XLEN == 64);

  if (XLEN == 64) begin : g_word
    // Lay the 32-bit word into the 64-bit lane so the full-width core yields the word result in [31:0].
    always_comb begin
      if (op_is_rotate(in_op))
        word_data = {in_a[31:0], in_a[31:0]};
      else if (in_op == SH_SRA)
        word_data = {{32{in_a[31]}}, in_a[31:0]};
      else
        word_data = {32'b0, in_a[31:0]};
    end
    assign sext_r = {{32{fin_norm[31]}}, fin_norm[31:0]};
  end else begin : g_noword
    assign word_data = in_a;
    assign sext_r    = fin_norm;
  end

  assign sel_data = word_eff ? word_data : in_a;

  for (genvar gi = 0; gi < XLEN; gi++) begin : g_rev
    assign sel_rev[gi] = sel_data[XLEN-1-gi];
    assign fin_rev[gi] = fin_data[XLEN-1-gi];
  end

  assign pre_data = op_is_left(in_op) ? sel_rev : sel_data;

  // Effective amount: word mode drops the top amount bit, pass-through ops shift by zero.
  always_comb begin
    shamt_eff = in_shamt;
    if (word_eff)
      shamt_eff[SHW-1] = 1'b0;
    if (op_is_pass(in_op))
      shamt_eff = '0;
  end

  // Payload offered to stage 0.
  always_comb begin
    in_payload                  = '0;
    in_payload.valid            = in_valid & in_ready;
    in_payload.op               = in_op;
    in_payload.word             = word_eff;
    in_payload.shamt[SHW-1:0]   = shamt_eff;
    in_payload.data[XLEN-1:0]   = pre_data;
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO = gi * LPS;
    localparam int NL = (LO >= SHW) ? 0 : (((SHW - LO) < LPS) ? (SHW - LO) : LPS);

    shift_payload_t          stage_cur;
    logic [XLEN-1:0]         stage_out;
    logic [MAX_XLEN-1:0]     data_ext;

    if (gi == 0) begin : g_head
      assign stage_cur = in_payload;
    end else begin : g_link
      assign stage_cur = stage_reg[gi-1];
    end

    shift_stage #(
      .XLEN      (XLEN),
      .FIRST_LVL (LO),
      .NUM_LVL   (NL)
    ) u_stage (
      .op       (stage_cur.op),
      .shamt    (stage_cur.shamt[SHW-1:0]),
      .data_in  (stage_cur.data[XLEN-1:0]),
      .data_out (stage_out)
    );

    // Widen the stage result back to payload width.
    always_comb begin
      data_ext            = '0;
      data_ext[XLEN-1:0]  = stage_out;
    end

    assign stage_next[gi] = '{valid: stage_cur.valid, op: stage_cur.op, word: stage_cur.word,
                              shamt: stage_cur.shamt, data: data_ext};
  end

  // Stage registers: flush clears valids, otherwise advance together or hold together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++)
        stage_reg[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < STAGES; i++)
        stage_reg[i].valid <= 1'b0;
    end else if (adv) begin
      for (int i = 0; i < STAGES; i++)
        stage_reg[i] <= stage_next[i];
    end
  end

  assign fin      = stage_reg[STAGES-1];
  assign fin_data = fin.data[XLEN-1:0];
  assign fin_norm = op_is_left(fin.op) ? fin_rev : fin_data;
  assign out_r    = fin.word ? sext_r : fin_norm;

endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed self-checking bench: a 32-bit/2-stage and a 64-bit/3-stage shifter side by side.
module tb_pipelined_shifter;
  import shift_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  logic        v32, ir32, ov32, rdy32, w32;
  logic [31:0] a32, r32;
  logic [4:0]  s32;
  logic [2:0]  op32;

  logic        v64, ir64, ov64, rdy64, w64;
  logic [63:0] a64, r64;
  logic [5:0]  s64;
  logic [2:0]  op64;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipelined_shifter #(.XLEN(32), .STAGES(2)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(v32), .in_ready(ir32), .in_a(a32), .in_shamt(s32), .in_op(op32), .in_word(w32),
    .out_valid(ov32), .out_ready(rdy32), .out_r(r32)
  );

  pipelined_shifter #(.XLEN(64), .STAGES(3)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(v64), .in_ready(ir64), .in_a(a64), .in_shamt(s64), .in_op(op64), .in_word(w64),
    .out_valid(ov64), .out_ready(rdy64), .out_r(r64)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One op through the 32-bit unit: not valid after one edge, result after two.
  task automatic run32(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [4:0] s, input logic [31:0] exp);
    v32 = 1'b1; op32 = op; a32 = a; s32 = s; rdy32 = 1'b1;
    @(posedge clk); #1;
    v32 = 1'b0;
    check({tag, "_lat1"}, {63'b0, ov32}, 64'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, {63'b0, ov32}, 64'd1);
    check(tag, {32'b0, r32}, {32'b0, exp});
    $display("op32 %s a=%h s=%0d r=%h", tag, a, s, r32);
    @(posedge clk); #1;
  endtask

  // One op through the 64-bit unit: result on the third edge.
  task automatic run64(input string tag, input logic [2:0] op, input logic word,
                       input logic [63:0] a, input logic [5:0] s, input logic [63:0] exp);
    v64 = 1'b1; op64 = op; w64 = word; a64 = a; s64 = s; rdy64 = 1'b1;
    @(posedge clk); #1;
    v64 = 1'b0;
    check({tag, "_lat1"}, {63'b0, ov64}, 64'd0);
    @(posedge clk); #1;
    check({tag, "_lat2"}, {63'b0, ov64}, 64'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, {63'b0, ov64}, 64'd1);
    check(tag, r64, exp);
    $display("op64 %s a=%h s=%0d w=%0b r=%h", tag, a, s, word, r64);
    @(posedge clk); #1;
  endtask

  logic [31:0] exp_bp [5];
  int idx, got, stall_left, stall_cycles;
  logic seen, hs_in, hs_out;

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    v32 = 0; rdy32 = 1; a32 = '0; s32 = '0; op32 = '0; w32 = 0;
    v64 = 0; rdy64 = 1; a64 = '0; s64 = '0; op64 = '0; w64 = 0;

    #12;
    check("rst_ov32", {63'b0, ov32}, 64'd0);
    check("rst_r32", {32'b0, r32}, 64'd0);
    check("rst_ov64", {63'b0, ov64}, 64'd0);
    check("rst_r64", r64, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ir32", {63'b0, ir32}, 64'd1);
    check("rst_ir64", {63'b0, ir64}, 64'd1);

    // Full-width 32-bit ops
    run32("sll31",  SH_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000);
    run32("sra4",   SH_SRA, 32'h8000_0000, 5'd4,  32'hF800_0000);
    run32("ror8",   SH_ROR, 32'h1234_5678, 5'd8,  32'h7812_3456);
    run32("rol0",   SH_ROL, 32'h1234_5678, 5'd0,  32'h1234_5678);
    run32("pass7",  3'b111, 32'hDEAD_BEEF, 5'd5,  32'hDEAD_BEEF);
    run32("srl31",  SH_SRL, 32'h8000_0000, 5'd31, 32'h0000_0001);
    run32("rol4",   SH_ROL, 32'h1234_5678, 5'd4,  32'h2345_6781);
    run32("sra16p", SH_SRA, 32'h7FFF_0000, 5'd16, 32'h0000_7FFF);
    run32("ror1",   SH_ROR, 32'h0000_0001, 5'd1,  32'h8000_0000);

    // 64-bit word and full-width ops
    run64("sraw36", SH_SRA, 1'b1, 64'h0000_0000_8000_0000, 6'd36, 64'hFFFF_FFFF_F800_0000);
    run64("sllw31", SH_SLL, 1'b1, 64'h0000_0000_0000_0001, 6'd31, 64'hFFFF_FFFF_8000_0000);
    run64("rolw1",  SH_ROL, 1'b1, 64'h0000_0000_4000_0001, 6'd1,  64'hFFFF_FFFF_8000_0002);
    run64("rorw1",  SH_ROR, 1'b1, 64'h0000_0000_0000_0003, 6'd1,  64'hFFFF_FFFF_8000_0001);
    run64("srlw1",  SH_SRL, 1'b1, 64'h1234_5678_8000_0000, 6'd1,  64'h0000_0000_4000_0000);
    run64("passw",  3'b101, 1'b1, 64'h0000_0000_FFFF_0000, 6'd9,  64'hFFFF_FFFF_FFFF_0000);
    run64("ror4",   SH_ROR, 1'b0, 64'h0123_4567_89AB_CDEF, 6'd4,  64'hF012_3456_789A_BCDE);
    run64("sra63",  SH_SRA, 1'b0, 64'h8000_0000_0000_0000, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF);
    run64("sll63",  SH_SLL, 1'b0, 64'h0000_0000_0000_0001, 6'd63, 64'h8000_0000_0000_0000);
    run64("rol32",  SH_ROL, 1'b0, 64'h8000_0000_0000_0001, 6'd32, 64'h0000_0001_8000_0000);

    // Backpressure: 5 back-to-back sll ops, 4 stalled cycles after the first result
    exp_bp[0] = 32'h0000_0001; exp_bp[1] = 32'h0000_0004; exp_bp[2] = 32'h0000_000C;
    exp_bp[3] = 32'h0000_0020; exp_bp[4] = 32'h0000_0050;
    idx = 0; got = 0; stall_left = 4; stall_cycles = 0; seen = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      v32 = (idx < 5); op32 = SH_SLL; a32 = idx + 1; s32 = idx[4:0];
      rdy32 = !(seen && stall_left > 0);
      if (!rdy32) stall_left--;
      @(negedge clk);
      if (ov32) begin
        seen = 1'b1;
        if (got < 5) begin
          check($sformatf("bp_r%0d", got), {32'b0, r32}, {32'b0, exp_bp[got]});
          $display("bp cycle=%0d result[%0d]=%h ready=%0b", cyc, got, r32, rdy32);
        end else begin
          check("bp_extra", {63'b0, ov32}, 64'd0);
        end
      end
      if (!rdy32) begin
        check("bp_in_ready", {63'b0, ir32}, 64'd0);
        check("bp_ov_hold", {63'b0, ov32}, 64'd1);
        stall_cycles++;
      end
      hs_in  = v32 && ir32;
      hs_out = ov32 && rdy32;
      @(posedge clk); #1;
      if (hs_in)  idx++;
      if (hs_out) got++;
    end
    v32 = 1'b0; rdy32 = 1'b1;
    check("bp_got", 64'(got), 64'd5);
    check("bp_idx", 64'(idx), 64'd5);
    check("bp_stalls", 64'(stall_cycles), 64'd4);
    @(negedge clk);
    check("bp_drained", {63'b0, ov32}, 64'd0);
    @(posedge clk); #1;

    // Flush with two ops in flight and the output stalled
    rdy32 = 1'b0; v32 = 1'b1; op32 = SH_SLL; a32 = 32'h0000_AAAA; s32 = 5'd1;
    @(posedge clk); #1;
    a32 = 32'h0000_5555;
    @(posedge clk); #1;
    v32 = 1'b0;
    check("fl_pre_ov", {63'b0, ov32}, 64'd1);
    flush = 1'b1; rdy32 = 1'b1; v32 = 1'b1; a32 = 32'h0000_1234;
    @(negedge clk);
    check("fl_in_ready", {63'b0, ir32}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; v32 = 1'b0;
    check("fl_ov", {63'b0, ov32}, 64'd0);
    $display("flush applied ov=%0b", ov32);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("fl_quiet", {63'b0, ov32}, 64'd0);
    end
    @(posedge clk); #1;

    // Asynchronous reset between edges with a result waiting
    rdy32 = 1'b0; v32 = 1'b1; op32 = SH_SRL; a32 = 32'hF000_0000; s32 = 5'd4;
    @(posedge clk); #1;
    v32 = 1'b0;
    @(posedge clk); #1;
    check("ar_pre_ov", {63'b0, ov32}, 64'd1);
    check("ar_pre_r", {32'b0, r32}, 64'h0000_0000_0F00_0000);
    #2 rst_n = 1'b0;
    #1;
    check("ar_ov", {63'b0, ov32}, 64'd0);
    check("ar_r", {32'b0, r32}, 64'd0);
    $display("async reset ov=%0b r=%h", ov32, r32);
    @(posedge clk); #2;
    rst_n = 1'b1;
    check("ar_ir", {63'b0, ir32}, 64'd1);
    @(negedge clk);
    check("ar_stale", {63'b0, ov32}, 64'd0);
    @(posedge clk); #1;
    run32("ar_rol4", SH_ROL, 32'h1234_5678, 5'd4, 32'h2345_6781);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
